// File: rtl/custom_sub.sv
`default_nettype none
// ============================================================================
//  Module      : custom_sub
//  Description : Two-stage valid/ready pipeline that recovers an operand
//                from an adder result: diff = sum - b, with err flagging a
//                result outside 0..2^WIDTH-1.
//                Stage S1 registers (sum, b); stage S2 registers (diff, err)
//                together with the output valid bit.
//  Ports       : clk       - clock, rising edge
//                rst       - asynchronous active-high reset
//                in_valid  - qualifies sum / b
//                in_ready  - operand pair accepted when in_valid & in_ready
//                sum       - minuend, WIDTH+1 bits
//                b         - subtrahend, WIDTH bits
//                out_valid - qualifies diff / err
//                out_ready - result consumed when out_valid & out_ready
//                diff      - recovered operand, WIDTH bits
//                err       - result below 0 or above 2^WIDTH-1
//                xfer_cnt  - wrapping count of consumed results
//  Options     : `define CUSTOM_SUB_SAT_EN to saturate diff on err
//                (0 when negative, all-ones when too large). Default wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module custom_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             err,
    output logic [15:0]      xfer_cnt
);

    // Stage registers
    logic             r_s1_valid;
    logic [WIDTH:0]   r_s1_sum;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_err;
    logic [15:0]      r_xfer_cnt;

    // Handshake / datapath wires
    logic             w_consume;
    logic             w_s2_load;
    logic             w_s1_load;
    logic [WIDTH+1:0] w_res;
    logic             w_neg;
    logic             w_over;
    logic [WIDTH-1:0] w_diff;

    assign w_consume = r_s2_valid & out_ready;
    assign w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);
    // Held low during reset so nothing is offered an accept while state is cleared
    assign in_ready  = ~rst & (~r_s1_valid | w_s2_load);
    assign w_s1_load = in_valid & in_ready;

    // Zero-extended to WIDTH+2 bits: the top bit is the sign of sum - b,
    // and bit WIDTH set on a non-negative result means it exceeds 2^WIDTH-1.
    assign w_res  = {1'b0, r_s1_sum} - {2'b00, r_s1_b};
    assign w_neg  = w_res[WIDTH+1];
    assign w_over = ~w_neg & w_res[WIDTH];

`ifdef CUSTOM_SUB_SAT_EN
    always_comb begin
        w_diff = w_res[WIDTH-1:0];
        if (w_neg) begin
            w_diff = '0;
        end else if (w_over) begin
            w_diff = '1;
        end
    end
`else
    assign w_diff = w_res[WIDTH-1:0];
`endif

    // Control and result registers: cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_err      <= 1'b0;
            r_xfer_cnt <= 16'h0000;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_diff     <= w_diff;
                r_err      <= w_neg | w_over;
            end else if (w_consume) begin
                r_s2_valid <= 1'b0;
            end

            if (w_consume) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
        end
    end

    // Operand capture needs no reset; it is qualified by r_s1_valid
    always_ff @(posedge clk) begin
        if (w_s1_load) begin
            r_s1_sum <= sum;
            r_s1_b   <= b;
        end
    end

    assign out_valid = r_s2_valid;
    assign diff      = r_diff;
    assign err       = r_err;
    assign xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire
